// File: rtl/key_event_scheduler.sv
// Queues keypad press pulses in a small FIFO and hands them to one consumer
// over valid/ready, with a programmable hold-off gap and a lost-event counter.
module key_event_scheduler #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_d,
  input  logic                     key_l,
  input  logic                     key_e,
  input  logic                     key_r,
  input  logic                     key_u,
  input  logic                     flush,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic [2:0]               ev_code,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [2:0] CODE_D = 3'd0;
  localparam logic [2:0] CODE_L = 3'd1;
  localparam logic [2:0] CODE_E = 3'd2;
  localparam logic [2:0] CODE_R = 3'd3;
  localparam logic [2:0] CODE_U = 3'd4;

  typedef enum logic [1:0] {IDLE, PRESENT, HOLDOFF} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            valid_nxt;
  logic [2:0]      code_nxt;
  logic            pop;
  logic            push;
  logic            any_key;
  logic            full;
  logic [2:0]      win_code;
  logic [2:0]      n_keys;
  logic [2:0]      drop_inc;
  logic [8:0]      drop_sum;
  logic [7:0]      drop_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [2:0]      mem [DEPTH];

  // Collision resolution: E > U > D > L > R; every non-winning pulse is lost.
  always_comb begin
    any_key  = key_d | key_l | key_e | key_r | key_u;
    n_keys   = 3'(key_d) + 3'(key_l) + 3'(key_e) + 3'(key_r) + 3'(key_u);
    win_code = CODE_D;
    if (key_e)      win_code = CODE_E;
    else if (key_u) win_code = CODE_U;
    else if (key_d) win_code = CODE_D;
    else if (key_l) win_code = CODE_L;
    else if (key_r) win_code = CODE_R;
  end

  // A full FIFO still accepts when the head leaves in the same cycle.
  always_comb begin
    full     = (level == LW'(DEPTH));
    push     = any_key && !flush && (!full || pop);
    drop_inc = 3'd0;
    if (any_key && !flush)
      drop_inc = (n_keys - 3'd1) + (push ? 3'd0 : 3'd1);
    drop_sum = 9'(drop_cnt) + 9'(drop_inc);
    drop_nxt = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // Output FSM: next state and registered ev_valid/ev_code values.
  always_comb begin
    state_nxt = state;
    valid_nxt = ev_valid;
    code_nxt  = ev_code;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (level != '0) begin
            state_nxt = PRESENT;
            valid_nxt = 1'b1;
            code_nxt  = mem[rd_ptr];
          end
        end
        PRESENT: begin
          if (ev_valid && ev_ready) begin
            pop       = 1'b1;
            valid_nxt = 1'b0;
            if (GAP_CYCLES == 0) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = HOLDOFF;
              cnt_nxt   = CW'(GAP_CYCLES - 1);
            end
          end
        end
        HOLDOFF: begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - CW'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ev_valid <= 1'b0;
      ev_code  <= 3'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ev_valid <= valid_nxt;
      ev_code  <= code_nxt;
      drop_cnt <= drop_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      level <= level + LW'(1);
        else if (pop && !push) level <= level - LW'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= win_code;
  end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler (DEPTH=4, GAP_CYCLES=3).
module tb_key_event_scheduler;

  localparam logic [4:0] K_D = 5'b00001;
  localparam logic [4:0] K_L = 5'b00010;
  localparam logic [4:0] K_E = 5'b00100;
  localparam logic [4:0] K_R = 5'b01000;
  localparam logic [4:0] K_U = 5'b10000;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       ev_ready;
  logic [4:0] keys;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic [2:0] level;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  key_event_scheduler #(.DEPTH(4), .GAP_CYCLES(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_d    (keys[0]),
    .key_l    (keys[1]),
    .key_e    (keys[2]),
    .key_r    (keys[3]),
    .key_u    (keys[4]),
    .flush    (flush),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .level    (level),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for an event, checks its code, then lets the handshake edge pass.
  task automatic expect_event(input string tag, input logic [2:0] code);
    for (int i = 0; i < 20 && ev_valid !== 1'b1; i++) tick();
    chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
    chk({tag, "_code"}, 32'(ev_code), 32'(code));
    tick();
  endtask

  task automatic pulse(input logic [4:0] k);
    keys = k;
    tick();
    keys = 5'd0;
  endtask

  logic [4:0] seq2 [6];
  logic [4:0] seq4 [4];

  initial begin
    seq2 = '{K_D, K_L, K_R, K_U, K_E, K_D};
    seq4 = '{K_U, K_R, K_L, K_D};
    rst = 1'b0; flush = 1'b0; ev_ready = 1'b0; keys = 5'd0;

    // Reset state
    #12;
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_code", 32'(ev_code), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    tick();
    rst = 1'b1;
    tick(); tick();

    // Single E pulse, latency and hold-off
    ev_ready = 1'b1;
    pulse(K_E);
    chk("t1_level1", 32'(level), 32'd1);
    chk("t1_valid_early", 32'(ev_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(ev_valid), 32'd1);
    chk("t1_code", 32'(ev_code), 32'd2);
    tick();
    chk("t1_valid_pop", 32'(ev_valid), 32'd0);
    chk("t1_level0", 32'(level), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_quiet", 32'(ev_valid), 32'd0);
    end

    // Overflow with stalled consumer, then ordered delivery
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) pulse(seq2[i]);
    chk("t2_level", 32'(level), 32'd4);
    chk("t2_drop", 32'(drop_cnt), 32'd2);
    chk("t2_valid", 32'(ev_valid), 32'd1);
    chk("t2_code", 32'(ev_code), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_valid", 32'(ev_valid), 32'd1);
      chk("t2_stall_code", 32'(ev_code), 32'd0);
    end
    ev_ready = 1'b1;
    tick();
    chk("t2_pop_valid", 32'(ev_valid), 32'd0);
    chk("t2_pop_level", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_gap", 32'(ev_valid), 32'd0);
    end
    tick();
    chk("t2_next_valid", 32'(ev_valid), 32'd1);
    chk("t2_next_code", 32'(ev_code), 32'd1);
    tick();
    expect_event("t2_r", 3'd3);
    expect_event("t2_u", 3'd4);
    chk("t2_level_end", 32'(level), 32'd0);

    // Same-cycle collision
    ev_ready = 1'b0;
    repeat (4) tick();
    pulse(K_D | K_R | K_U | K_E);
    chk("t3_level", 32'(level), 32'd1);
    chk("t3_drop", 32'(drop_cnt), 32'd5);
    tick();
    chk("t3_valid", 32'(ev_valid), 32'd1);
    chk("t3_code", 32'(ev_code), 32'd2);

    // Full FIFO with simultaneous pop and push
    pulse(K_D); pulse(K_R); pulse(K_U);
    chk("t4_level_full", 32'(level), 32'd4);
    chk("t4_code_held", 32'(ev_code), 32'd2);
    ev_ready = 1'b1;
    pulse(K_L);
    chk("t4_level_same", 32'(level), 32'd4);
    chk("t4_drop_same", 32'(drop_cnt), 32'd5);
    chk("t4_valid_pop", 32'(ev_valid), 32'd0);
    expect_event("t4_d", 3'd0);
    expect_event("t4_r", 3'd3);
    expect_event("t4_u", 3'd4);
    expect_event("t4_l", 3'd1);
    chk("t4_level_empty", 32'(level), 32'd0);
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(seq4[i]);
    chk("t4_wrap_level", 32'(level), 32'd4);
    ev_ready = 1'b1;
    expect_event("t4_wrap_u", 3'd4);
    expect_event("t4_wrap_r", 3'd3);
    expect_event("t4_wrap_l", 3'd1);
    expect_event("t4_wrap_d", 3'd0);
    chk("t4_wrap_empty", 32'(level), 32'd0);
    chk("t4_wrap_drop", 32'(drop_cnt), 32'd5);

    // Flush while presenting, with a same-cycle pulse and handshake
    ev_ready = 1'b0;
    repeat (5) tick();
    pulse(K_D); pulse(K_L); pulse(K_E);
    chk("t5_level", 32'(level), 32'd3);
    chk("t5_valid", 32'(ev_valid), 32'd1);
    flush = 1'b1; ev_ready = 1'b1; keys = K_U;
    tick();
    flush = 1'b0; keys = 5'd0;
    chk("t5_valid_flush", 32'(ev_valid), 32'd0);
    chk("t5_level_flush", 32'(level), 32'd0);
    chk("t5_drop_flush", 32'(drop_cnt), 32'd5);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_event", 32'(ev_valid), 32'd0);
    end
    chk("t5_level_after", 32'(level), 32'd0);

    // drop_cnt saturation over 300 lost events
    ev_ready = 1'b0;
    repeat (4) pulse(K_D);
    chk("t6_level", 32'(level), 32'd4);
    pulse(5'b11111);
    chk("t6_drop_burst", 32'(drop_cnt), 32'd10);
    keys = K_D;
    repeat (200) tick();
    chk("t6_drop_mid", 32'(drop_cnt), 32'd210);
    repeat (45) tick();
    chk("t6_drop_edge", 32'(drop_cnt), 32'd255);
    repeat (50) tick();
    keys = 5'd0;
    chk("t6_drop_sat", 32'(drop_cnt), 32'd255);
    chk("t6_level_end", 32'(level), 32'd4);

    // Reset during hold-off with two entries queued
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t7_level_flush", 32'(level), 32'd0);
    chk("t7_drop_kept", 32'(drop_cnt), 32'd255);
    pulse(K_D); pulse(K_L); pulse(K_R);
    chk("t7_level3", 32'(level), 32'd3);
    chk("t7_valid", 32'(ev_valid), 32'd1);
    ev_ready = 1'b1;
    tick();
    chk("t7_pop_valid", 32'(ev_valid), 32'd0);
    chk("t7_level2", 32'(level), 32'd2);
    tick();
    rst = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(ev_valid), 32'd0);
    chk("t7_rst_code", 32'(ev_code), 32'd0);
    chk("t7_rst_level", 32'(level), 32'd0);
    chk("t7_rst_drop", 32'(drop_cnt), 32'd0);
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("t7_idle_valid", 32'(ev_valid), 32'd0);
    chk("t7_idle_level", 32'(level), 32'd0);
    pulse(K_R);
    chk("t7_new_level", 32'(level), 32'd1);
    chk("t7_new_early", 32'(ev_valid), 32'd0);
    tick();
    chk("t7_new_valid", 32'(ev_valid), 32'd1);
    chk("t7_new_code", 32'(ev_code), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
